sram_ctrl: RTL and testbench

Sequencing controller for the external 16-bit data SRAM behind the MEM stage. It converts the 32-bit `MEM_R_EN`/`MEM_W_EN` requests produced by the control unit into two half-word SRAM accesses with programmable wait states. It drives `ready` low to freeze the pipeline until the word transfer completes.

---
 rtl/sram_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: turns 32-bit MEM-stage word requests into two 16-bit SRAM phases with wait states.
// Define SRAM_READ_BUF_EN to compile in a one-entry read buffer (word tag + valid).
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_dq_in,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_ce_n
);
    localparam int unsigned CNT_W =
        ($clog2(WAIT_CYCLES + 1) > 2) ? $clog2(WAIT_CYCLES + 1) : 2;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WAIT_CYCLES);
    localparam int unsigned WORD_W = ADDR_W - 1;

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              is_wr_q, is_wr_d;
    logic [31:0]       offset;
    logic [WORD_W-1:0] req_word;
    logic              req, hit, phase_end;
    logic              unused_offset;

    // Word index wraps modulo the SRAM size; the dropped bits are intentionally ignored.
    assign offset        = address - BASE_ADDR;
    assign req_word      = offset[WORD_W+1:2];
    assign unused_offset = ^{offset[31:WORD_W+2], offset[1:0]};

`ifdef SRAM_READ_BUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [WORD_W-1:0] buf_tag_q, buf_tag_d;

    assign hit = MEM_R_EN && !MEM_W_EN && buf_valid_q && (buf_tag_q == req_word);

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        if (state_q == StIdle && MEM_W_EN) begin
            buf_valid_d = 1'b0;
        end else if (state_q == StDone && !is_wr_q) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = word_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign req       = (MEM_R_EN || MEM_W_EN) && !hit;
    assign phase_end = (cnt_q == CNT_END);
    assign rdata     = rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        is_wr_d     = is_wr_q;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_ce_n   = 1'b1;
        unique case (state_q)
            StIdle: begin
                ready = !req;
                if (req) begin
                    state_d = StLo;
                    cnt_d   = '0;
                    word_d  = req_word;
                    wdata_d = wdata;
                    is_wr_d = MEM_W_EN;
                end
            end
            StLo, StHi: begin
                sram_ce_n = 1'b0;
                sram_addr = {word_q, state_q == StHi};
                if (is_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = (state_q == StHi) ? wdata_q[31:16] : wdata_q[15:0];
                end
                if (phase_end) begin
                    cnt_d = '0;
                    if (state_q == StLo) begin
                        state_d = StHi;
                        if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
                    end else begin
                        state_d = StDone;
                        if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_wr_q <= is_wr_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: W=1 instance driven from a vector table with an rdata scoreboard,
// plus a W=3 instance for phase-length checks and hand-written reset/idle sequences.
module tb_sram_ctrl;
    logic        clk, rst_n;
    logic [31:0] address, wdata;
    logic        r1, w1, r3, w3;
    logic [31:0] rdata1, rdata3;
    logic        ready1, ready3;
    logic [17:0] addr1, addr3;
    logic [15:0] dqin1, dqout1, dqin3, dqout3;
    logic        oe1, we1, ce1, oe3, we3, ce3;

    logic [15:0] mem1 [0:(1<<18)-1];
    logic [15:0] mem3 [0:(1<<18)-1];
    logic [31:0] sb_q [$];
    int checks = 0;
    int errors = 0;

`ifdef SRAM_READ_BUF_EN
    localparam int HIT_LAT = 0;
`else
    localparam int HIT_LAT = 5;
`endif

    sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .MEM_R_EN(r1), .MEM_W_EN(w1), .address(address),
        .wdata(wdata), .rdata(rdata1), .ready(ready1), .sram_addr(addr1), .sram_dq_in(dqin1),
        .sram_dq_out(dqout1), .sram_dq_oe(oe1), .sram_we_n(we1), .sram_ce_n(ce1)
    );

    sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .MEM_R_EN(r3), .MEM_W_EN(w3), .address(address),
        .wdata(wdata), .rdata(rdata3), .ready(ready3), .sram_addr(addr3), .sram_dq_in(dqin3),
        .sram_dq_out(dqout3), .sram_dq_oe(oe3), .sram_we_n(we3), .sram_ce_n(ce3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAMs: synchronous write on strobe, asynchronous read.
    always @(posedge clk) if (!ce1 && !we1) mem1[addr1] <= dqout1;
    always @(posedge clk) if (!ce3 && !we3) mem3[addr3] <= dqout3;
    assign dqin1 = mem1[addr1];
    assign dqin3 = mem3[addr3];

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request on dut1, holds it until ready, then pops the scoreboard against rdata.
    task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd,
                           output int lat, output logic ce_seen);
        logic [31:0] exp;
        @(negedge clk);
        address = a;
        wdata   = d;
        r1      = r;
        w1      = w;
        sb_q.push_back(exp_rd);
        lat     = -1;
        ce_seen = 1'b0;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (!ce1) ce_seen = 1'b1;
            if (ready1) begin
                lat = cyc;
                break;
            end
        end
        r1 = 1'b0;
        w1 = 1'b0;
        exp = sb_q.pop_front();
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: ready never rose for address %h", a);
        end else begin
            check("rdata", rdata1, exp);
        end
    endtask

    initial begin
        int          lat;
        logic        ce_seen;
        logic [31:0] exp_addr;

        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 5};
        vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 5};
        vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, HIT_LAT};
        vecs[3] = '{1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 32'hDEADBEEF, 5};
        vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 5};
        vecs[5] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 5};
        vecs[6] = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'hCAFEF00D, 5};
        vecs[7] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 5};

        rst_n   = 1'b0;
        r1      = 1'b0;
        w1      = 1'b0;
        r3      = 1'b0;
        w3      = 1'b0;
        address = '0;
        wdata   = '0;
        #1;
        check("rst_ready", 32'(ready1), 32'd1);
        check("rst_ce_n", 32'(ce1), 32'd1);
        check("rst_we_n", 32'(we1), 32'd1);
        check("rst_oe", 32'(oe1), 32'd0);
        check("rst_rdata", rdata1, 32'h0);
        check("rst_addr", 32'(addr1), 32'h0);
        check("rst_dq_out", 32'(dqout1), 32'h0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, lat, ce_seen);
            check($sformatf("latency[%0d]", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("ce_active[%0d]", i), 32'(ce_seen), 32'(vecs[i].exp_lat != 0));
        end

        check("mem0", 32'(mem1[0]), 32'h0000BEEF);
        check("mem1", 32'(mem1[1]), 32'h0000DEAD);
        check("mem2", 32'(mem1[2]), 32'h00005678);
        check("mem3", 32'(mem1[3]), 32'h00001234);
        check("mem8", 32'(mem1[8]), 32'h0000F00D);
        check("mem9", 32'(mem1[9]), 32'h0000CAFE);

        // W=3 at 1032: each half-word phase is 4 cycles, ready at cycle 9.
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            address = 32'd1032;
            wdata   = 32'h5A5AA5A5;
            w3      = (op == 0);
            r3      = (op == 1);
            #1;
            check("w3_ready_c0", 32'(ready3), 32'd0);
            for (int cyc = 1; cyc <= 9; cyc++) begin
                @(negedge clk);
                #1;
                w3 = 1'b0;
                r3 = 1'b0;
                check($sformatf("w3_ready_c%0d", cyc), 32'(ready3), 32'(cyc == 9));
                if (cyc <= 8) begin
                    exp_addr = (cyc <= 4) ? 32'd4 : 32'd5;
                    check($sformatf("w3_addr_c%0d", cyc), 32'(addr3), exp_addr);
                    check($sformatf("w3_oe_c%0d", cyc), 32'(oe3), 32'(op == 0));
                end
            end
            if (op == 1) check("w3_rdata", rdata3, 32'h5A5AA5A5);
        end
        check("w3_mem4", 32'(mem3[4]), 32'h0000A5A5);
        check("w3_mem5", 32'(mem3[5]), 32'h00005A5A);

        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            #1;
            check("idle_ready", 32'(ready1), 32'd1);
            check("idle_ce_n", 32'(ce1), 32'd1);
        end

        // Reset in the middle of a write's LO phase.
        @(negedge clk);
        address = 32'd1024;
        wdata   = 32'h11112222;
        w1      = 1'b1;
        @(negedge clk);
        #1;
        check("mid_lo_we_n", 32'(we1), 32'd0);
        w1    = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_we_n", 32'(we1), 32'd1);
        check("async_ce_n", 32'(ce1), 32'd1);
        check("async_rdata", rdata1, 32'h0);
        check("async_ready", 32'(ready1), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", 32'(ready1), 32'd1);
        check("post_rst_ce_n", 32'(ce1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
